// File: rtl/sipo_framer_pkg.sv
// Shared types and default constants for the SIPO word framer.
// The state encoding is visible to anything that imports this package.
package sipo_framer_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } framer_state_e;

   localparam logic [15:0] SYNC_WORD_DEF     = 16'hA5C3;
   localparam int          PAYLOAD_WORDS_DEF = 4;

endpackage

// File: rtl/framer_slot_counter.sv
// Flywheel slot timer: bit and word counters that mark payload and sync
// boundaries relative to the last restart or sync-check edge.
module framer_slot_counter
   import sipo_framer_pkg::*;
#(
   parameter int  DATA_WIDTH    = 16,
   parameter int  PAYLOAD_WORDS = PAYLOAD_WORDS_DEF,
   localparam int BIT_W         = $clog2(DATA_WIDTH),
   localparam int WORD_W        = $clog2(PAYLOAD_WORDS + 1),
   localparam int IDX_W         = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             restart,
   output logic             payload_stb,
   output logic             sync_stb,
   output logic [IDX_W-1:0] idx
);

   logic [BIT_W-1:0]  bit_cnt_reg;
   logic [WORD_W-1:0] word_cnt_reg;
   logic              boundary;

   // The edge that completes a full word in the window is the last bit slot.
   assign boundary    = (bit_cnt_reg == BIT_W'(DATA_WIDTH - 1));
   assign payload_stb = boundary && (word_cnt_reg < WORD_W'(PAYLOAD_WORDS));
   assign sync_stb    = boundary && (word_cnt_reg == WORD_W'(PAYLOAD_WORDS));
   assign idx         = word_cnt_reg[IDX_W-1:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bit_cnt_reg  <= '0;
         word_cnt_reg <= '0;
      end else if (restart) begin
         bit_cnt_reg  <= '0;
         word_cnt_reg <= '0;
      end else if (boundary) begin
         bit_cnt_reg  <= '0;
         word_cnt_reg <= sync_stb ? '0 : word_cnt_reg + WORD_W'(1);
      end else begin
         bit_cnt_reg  <= bit_cnt_reg + BIT_W'(1);
      end
   end

endmodule

// File: rtl/sipo_word_framer.sv
// Sync-word hunter and payload aligner fed by the SIPO sliding window.
// SEARCH finds a candidate, VERIFY confirms periodicity, LOCKED emits words.
module sipo_word_framer
   import sipo_framer_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 16,
   parameter logic [DATA_WIDTH-1:0] SYNC_WORD     = DATA_WIDTH'(SYNC_WORD_DEF),
   parameter int                    PAYLOAD_WORDS = PAYLOAD_WORDS_DEF,
   parameter int                    LOCK_COUNT    = 3,
   parameter int                    LOSS_COUNT    = 2,
   localparam int                   IDX_W         = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [DATA_WIDTH-1:0] win,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_valid,
   output logic [IDX_W-1:0]      word_idx,
   output logic                  locked,
   output logic                  sync_err
);

   localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W = $clog2(LOSS_COUNT + 1);

   framer_state_e     state_reg;
   logic [HIT_W-1:0]  hit_cnt_reg;
   logic [MISS_W-1:0] miss_cnt_reg;
   logic              match;
   logic              restart;
   logic              payload_stb;
   logic              sync_stb;
   logic [IDX_W-1:0]  slot_idx;

   assign match   = (win == SYNC_WORD);
   // Only a fresh detection re-phases the flywheel; later checks wrap naturally.
   assign restart = (state_reg == SEARCH) && match;

   framer_slot_counter #(
      .DATA_WIDTH    (DATA_WIDTH),
      .PAYLOAD_WORDS (PAYLOAD_WORDS)
   ) u_slot (
      .clk         (clk),
      .resetn      (resetn),
      .restart     (restart),
      .payload_stb (payload_stb),
      .sync_stb    (sync_stb),
      .idx         (slot_idx)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg    <= SEARCH;
         hit_cnt_reg  <= '0;
         miss_cnt_reg <= '0;
         word         <= '0;
         word_valid   <= 1'b0;
         word_idx     <= '0;
         locked       <= 1'b0;
         sync_err     <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         sync_err   <= 1'b0;
         case (state_reg)
            SEARCH: begin
               if (match) begin
                  hit_cnt_reg  <= HIT_W'(1);
                  miss_cnt_reg <= '0;
                  if (LOCK_COUNT == 1) begin
                     state_reg <= LOCKED;
                     locked    <= 1'b1;
                  end else begin
                     state_reg <= VERIFY;
                  end
               end
            end
            VERIFY: begin
               if (sync_stb) begin
                  if (match) begin
                     if (int'(hit_cnt_reg) + 1 >= LOCK_COUNT) begin
                        state_reg    <= LOCKED;
                        locked       <= 1'b1;
                        miss_cnt_reg <= '0;
                        hit_cnt_reg  <= HIT_W'(LOCK_COUNT);
                     end else begin
                        hit_cnt_reg <= hit_cnt_reg + HIT_W'(1);
                     end
                  end else begin
                     state_reg   <= SEARCH;
                     hit_cnt_reg <= '0;
                  end
               end
            end
            LOCKED: begin
               if (payload_stb) begin
                  word       <= win;
                  word_idx   <= slot_idx;
                  word_valid <= 1'b1;
               end
               if (sync_stb) begin
                  if (match) begin
                     miss_cnt_reg <= '0;
                  end else begin
                     sync_err <= 1'b1;
                     if (int'(miss_cnt_reg) + 1 >= LOSS_COUNT) begin
                        state_reg    <= SEARCH;
                        locked       <= 1'b0;
                        hit_cnt_reg  <= '0;
                        miss_cnt_reg <= '0;
                     end else begin
                        miss_cnt_reg <= miss_cnt_reg + MISS_W'(1);
                     end
                  end
               end
            end
            default: begin
               state_reg <= SEARCH;
               locked    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sipo_word_framer.sv
// Bench for sipo_word_framer: MSB-first bits through a reference SIPO,
// frame table plus hand sequences, scoreboard queue of timed expectations.
module tb_sipo_word_framer;
   import sipo_framer_pkg::*;

   localparam logic [15:0] SYNC = 16'hA5C3;
   localparam logic [15:0] BAD  = 16'hA5C2;

   typedef enum int {K_WORD, K_ERR, K_LOCK} kind_e;
   typedef struct {
      int          due;
      kind_e       kind;
      logic [15:0] val;
      logic [1:0]  idx;
   } exp_t;
   typedef struct {
      logic [15:0]       sync;
      logic [3:0][15:0]  pay;
      bit                exp_locked;
      bit                exp_err;
   } frame_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic [15:0] win;
   logic [15:0] word;
   logic        word_valid;
   logic [1:0]  word_idx;
   logic        locked;
   logic        sync_err;

   int   total;
   int   bad;
   int   nb;
   exp_t sb[$];
   frame_t tbl[14];
   frame_t tbl2[4];

   always #5 clk = ~clk;

   sipo_word_framer dut (
      .clk        (clk),
      .resetn     (resetn),
      .win        (win),
      .word       (word),
      .word_valid (word_valid),
      .word_idx   (word_idx),
      .locked     (locked),
      .sync_err   (sync_err)
   );

   function automatic frame_t mk(input logic [15:0] s, input logic [15:0] base,
                                 input bit lk, input bit er);
      frame_t f;
      f.sync = s;
      for (int k = 0; k < 4; k++) f.pay[k] = base + 16'(k + 1);
      f.exp_locked = lk;
      f.exp_err    = er;
      return f;
   endfunction

   task automatic push(input kind_e k, input logic [15:0] v, input int i);
      exp_t e;
      e.due  = nb;
      e.kind = k;
      e.val  = v;
      e.idx  = 2'(i);
      sb.push_back(e);
   endtask

   // Outputs seen here respond to the window holding bit number nb.
   task automatic check_cycle();
      exp_t e;
      bit got_word = 0;
      bit got_err  = 0;
      while (sb.size() > 0 && sb[0].due <= nb) begin
         e = sb.pop_front();
         total++;
         case (e.kind)
            K_WORD: begin
               got_word = 1;
               if (!(word_valid === 1'b1 && word === e.val && word_idx === e.idx)) begin
                  bad++;
                  $display("FAIL word@%0d: got valid=%0b word=%h idx=%0d, want valid=1 word=%h idx=%0d",
                           nb, word_valid, word, word_idx, e.val, e.idx);
               end else begin
                  $display("word idx=%0d data=%h at bit %0d", word_idx, word, nb);
               end
            end
            K_ERR: begin
               got_err = 1;
               if (sync_err !== 1'b1) begin
                  bad++;
                  $display("FAIL sync_err@%0d: got %0b, want 1", nb, sync_err);
               end
            end
            default: begin
               if (locked !== e.val[0]) begin
                  bad++;
                  $display("FAIL locked@%0d: got %0b, want %0b", nb, locked, e.val[0]);
               end
            end
         endcase
      end
      if (word_valid !== 1'b0 && !got_word) begin
         total++; bad++;
         $display("FAIL stray_valid@%0d: got valid=%0b word=%h, want valid=0", nb, word_valid, word);
      end
      if (sync_err !== 1'b0 && !got_err) begin
         total++; bad++;
         $display("FAIL stray_sync_err@%0d: got %0b, want 0", nb, sync_err);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      check_cycle();
      win = {win[14:0], b};
      nb++;
   endtask

   task automatic send_bits(input logic [15:0] v, input int n);
      for (int i = 15; i > 15 - n; i--) send_bit(v[i]);
   endtask

   // Random filler that never forms the sync pattern in the window.
   task automatic send_rand(input int n);
      logic b;
      for (int i = 0; i < n; i++) begin
         b = 1'($urandom_range(0, 1));
         if ({win[14:0], b} == SYNC) b = ~b;
         send_bit(b);
      end
   endtask

   task automatic send_frame(input frame_t f);
      send_bits(f.sync, 16);
      push(K_LOCK, {15'd0, f.exp_locked}, 0);
      if (f.exp_err) push(K_ERR, 16'd0, 0);
      for (int k = 0; k < 4; k++) begin
         send_bits(f.pay[k], 16);
         if (f.exp_locked) push(K_WORD, f.pay[k], k);
      end
   endtask

   task automatic check_zero(input string name);
      total++;
      if (word !== 16'd0 || word_valid !== 1'b0 || word_idx !== 2'd0 ||
          locked !== 1'b0 || sync_err !== 1'b0) begin
         bad++;
         $display("FAIL %s: got word=%h valid=%0b idx=%0d locked=%0b err=%0b, want all 0",
                  name, word, word_valid, word_idx, locked, sync_err);
      end
   endtask

   task automatic check_state(input framer_state_e want, input string name);
      total++;
      if (dut.state_reg !== want || locked !== 1'b0) begin
         bad++;
         $display("FAIL %s: got state=%0d locked=%0b, want state=%0d locked=0",
                  name, dut.state_reg, locked, want);
      end
   endtask

   initial begin
      #200us;
      $display("FAIL timeout: simulation did not complete, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      total  = 0;
      bad    = 0;
      nb     = 0;
      resetn = 1'b0;
      win    = 16'd0;

      tbl[0]  = mk(SYNC, 16'h0000, 0, 0);
      tbl[1]  = mk(SYNC, 16'h0000, 0, 0);
      tbl[2]  = mk(SYNC, 16'h0000, 1, 0);
      tbl[3]  = mk(SYNC, 16'h0000, 1, 0);
      tbl[4]  = mk(BAD,  16'h0010, 1, 1);
      tbl[5]  = mk(SYNC, 16'h0020, 1, 0);
      tbl[6]  = mk(BAD,  16'h0030, 1, 1);
      tbl[7]  = mk(SYNC, 16'h0040, 1, 0);
      tbl[7].pay[1] = SYNC;
      tbl[8]  = mk(BAD,  16'h0050, 1, 1);
      tbl[9]  = mk(BAD,  16'h0060, 0, 1);
      tbl[10] = mk(SYNC, 16'h0070, 0, 0);
      tbl[11] = mk(SYNC, 16'h0080, 0, 0);
      tbl[12] = mk(SYNC, 16'h0090, 1, 0);
      tbl[13] = mk(SYNC, 16'h00A0, 1, 0);
      for (int i = 0; i < 4; i++) tbl2[i] = mk(SYNC, 16'h0100, (i >= 2), 0);

      // Reset held with random bits, then one cycle after release.
      for (int i = 0; i < 5; i++) begin
         send_rand(1);
         check_zero("reset_hold");
      end
      resetn = 1'b1;
      send_rand(1);
      check_zero("after_release");
      $display("reset phase done");

      // Lone sync with no repeat one frame later.
      send_rand(20);
      send_bits(SYNC, 16);
      send_rand(80);
      check_state(VERIFY, "false_sync_verify");
      send_rand(1);
      check_state(SEARCH, "false_sync_search");
      send_rand(40);
      $display("false sync phase done");

      send_rand(9);
      for (int i = 0; i < 14; i++) begin
         send_frame(tbl[i]);
         $display("frame %0d sync=%h locked_exp=%0b err_exp=%0b", i, tbl[i].sync,
                  tbl[i].exp_locked, tbl[i].exp_err);
      end

      // Reset asserted part-way through payload word 2 of a locked frame.
      send_bits(SYNC, 16);
      push(K_LOCK, 16'd1, 0);
      send_bits(16'h0B01, 16);
      push(K_WORD, 16'h0B01, 0);
      send_bits(16'h0B02, 16);
      push(K_WORD, 16'h0B02, 1);
      send_bits(16'h0B03, 8);
      #2;
      resetn = 1'b0;
      #1;
      check_zero("midframe_reset");
      sb.delete();
      for (int i = 0; i < 3; i++) begin
         send_rand(1);
         check_zero("midframe_reset_hold");
      end
      resetn = 1'b1;
      send_rand(30);
      for (int i = 0; i < 4; i++) begin
         send_frame(tbl2[i]);
         $display("relock frame %0d locked_exp=%0b", i, tbl2[i].exp_locked);
      end
      send_rand(3);

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
